// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg -- shared definitions for the PLA onset sweeper.
//   state_t       : sweeper control states
//   DEFAULT_N_IN  : default cone input width
//   MISR_POLY     : x^16 + x^12 + x^5 + 1 feedback taps
//   MISR_SEED     : signature value after reset and on every start
//   misr_step()   : one shift of the 16-bit multiple-input signature register
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          DEFAULT_N_IN = 16;
  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] MISR_SEED    = 16'hFFFF;

  // Galois-style shift with the parallel input word folded in.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [15:0] din);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ din;
  endfunction

endpackage

// File: rtl/pla_sweep_out_reg.sv
// pla_sweep_out_reg -- one-entry valid/ready holding register for onset minterms.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture data and raise m_valid (only asserted when !stall)
//   data       : minterm to capture
//   m_ready    : consumer accepts when m_valid && m_ready
//   m_valid    : holding register occupied
//   m_data     : held minterm
//   stall      : m_valid && !m_ready, the producer must hold its state
module pla_sweep_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         stall
);

  assign stall = m_valid && !m_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      // NOTE: the data register is reset too because its value is visible
      // on the port straight out of reset.
      m_data  <= '0;
    end else if (load) begin
      // Reloading in the same cycle as an acceptance keeps m_valid high,
      // which sustains one minterm per cycle.
      m_data  <= data;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pla_onset_sweeper.sv
// pla_onset_sweeper -- drives every N_IN-bit vector onto a single-output
// combinational cone, counts the onset and streams each onset minterm out.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (honoured only in IDLE or DONE)
//   x_o        : vector driven to the cone; y_i is its combinational result
//   busy       : high while sweeping or draining the last minterm
//   done       : one-cycle pulse at sweep completion
//   onset_cnt  : onset vectors seen in the last / current sweep
//   m_valid, m_data, m_ready : valid/ready stream of onset minterms
//   signature  : 16-bit MISR over {y_i, x_o[14:0]}, present only when the
//                PLA_SWEEP_MISR_EN macro is defined
module pla_onset_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int N_IN  = DEFAULT_N_IN,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  x_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] onset_cnt,
  output logic             m_valid,
  output logic [N_IN-1:0]  m_data,
  input  logic             m_ready
`ifdef PLA_SWEEP_MISR_EN
 ,output logic [15:0]      signature
`endif
);

  localparam logic [N_IN-1:0] X_LAST = '1;

  state_t state;
  logic   stall;
  logic   load;

  // While stalled the current vector is not consumed; it is re-evaluated
  // once the held minterm drains, so nothing is lost or duplicated.
  assign load = (state == SWEEP) && !stall && y_i;

  pla_sweep_out_reg #(.W(N_IN)) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data    (x_o),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .stall   (stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_o       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      onset_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            x_o       <= '0;
            onset_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SWEEP: begin
          if (!stall) begin
            if (y_i) onset_cnt <= onset_cnt + CNT_W'(1);
            // The all-ones vector is the last one; x_o parks there.
            if (x_o == X_LAST) state <= DRAIN;
            else               x_o   <= x_o + N_IN'(1);
          end
        end
        DRAIN: begin
          if (!m_valid || m_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLA_SWEEP_MISR_EN
  logic [14:0] x_low;

  if (N_IN >= 15) begin : g_x_wide
    assign x_low = x_o[14:0];
  end else begin : g_x_narrow
    assign x_low = {{(15 - N_IN){1'b0}}, x_o};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= MISR_SEED;
    end else if ((state == IDLE || state == DONE) && start) begin
      signature <= MISR_SEED;
    end else if (state == SWEEP && !stall) begin
      signature <= misr_step(signature, {y_i, x_low});
    end
  end
`endif

endmodule

// File: tb/tb_pla_onset_sweeper.sv
// tb_pla_onset_sweeper -- self-checking bench for pla_onset_sweeper.
// A 16-bit instance covers reset, mid-sweep reset, the full-rate sweep of the
// test cone and start-while-busy; a 12-bit instance covers backpressure,
// the constant cone, restart from DONE and (with PLA_SWEEP_MISR_EN) the
// signature. Expected minterm lists come from enumerating the cone formula.
module tb_pla_onset_sweeper;

  typedef logic [15:0] vq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // 16-bit instance (default parameters)
  logic        start_a, ready_a, y_a, busy_a, done_a, valid_a;
  logic [15:0] x_a, data_a;
  logic [16:0] cnt_a;
  // 12-bit instance
  logic        start_b, ready_b, y_b, busy_b, done_b, valid_b;
  logic [11:0] x_b, data_b;
  logic [12:0] cnt_b;
  int          mode_b;
`ifdef PLA_SWEEP_MISR_EN
  logic [15:0] sig_a, sig_b;
`endif

  vq_t got_a, got_b;
  bit  mon_b = 1'b0;

  // mode 0: test cone, 1: constant one, 2: test cone with minterm 0x00E0 removed
  function automatic logic cone_f(input logic [15:0] x, input int mode);
    logic f;
    f = !x[0] && !x[1] && !x[2] && !x[3] && x[6] && x[7] && !x[10] && !x[11]
        && (x[5] ? !x[4] : (x[4] && (x[8] ^ x[9])));
    if (mode == 1) return 1'b1;
    if (mode == 2) return f && (x != 16'h00E0);
    return f;
  endfunction

  function automatic vq_t model_list(input int n, input int mode);
    vq_t q;
    for (int v = 0; v < (1 << n); v++)
      if (cone_f(16'(v), mode)) q.push_back(16'(v));
    return q;
  endfunction

  function automatic bit q_has(input vq_t q, input logic [15:0] v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  assign y_a = cone_f(x_a, 0);
  assign y_b = cone_f({4'b0000, x_b}, mode_b);

  pla_onset_sweeper dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .x_o       (x_a),
    .y_i       (y_a),
    .busy      (busy_a),
    .done      (done_a),
    .onset_cnt (cnt_a),
    .m_valid   (valid_a),
    .m_data    (data_a),
    .m_ready   (ready_a)
`ifdef PLA_SWEEP_MISR_EN
   ,.signature (sig_a)
`endif
  );

  pla_onset_sweeper #(.N_IN(12), .CNT_W(13)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .x_o       (x_b),
    .y_i       (y_b),
    .busy      (busy_b),
    .done      (done_b),
    .onset_cnt (cnt_b),
    .m_valid   (valid_b),
    .m_data    (data_b),
    .m_ready   (ready_b)
`ifdef PLA_SWEEP_MISR_EN
   ,.signature (sig_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_list(input string tag, input vq_t got, input vq_t exp);
    int bad = 0;
    if (got.size() != exp.size()) bad = 1 + got.size();
    else foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Accepted beats, captured at the handshake edge.
  always @(posedge clk) begin
    if (valid_a && ready_a) got_a.push_back(data_a);
    if (valid_b && ready_b) got_b.push_back({4'b0000, data_b});
  end

  // While the held minterm is refused, the driven vector must not move.
  always @(posedge clk) begin : stall_mon
    logic [11:0] held;
    if (mon_b && busy_b && valid_b && !ready_b) begin
      held = x_b;
      #1 check("stall_hold_x", x_b, held);
    end
  end

  // Called at a negedge just after start was released (one edge consumed).
  task automatic wait_done_b(input bit rnd, output int cyc);
    cyc = 1;
    while (!done_b && cyc < 10000) begin
      if (rnd) ready_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    ready_b = 1'b1;
    check("b_done_seen", done_b, 1);
  endtask

  task automatic run_b(input bit rnd, output int cyc);
    got_b.delete();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_done_b(rnd, cyc);
  endtask

  initial begin
    int cyc;
    int seed_val;
`ifdef PLA_SWEEP_MISR_EN
    logic [15:0] sig1, sig2;
`endif
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; mode_b = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_x",     x_a,     0);
    check("rst_busy",  busy_a,  0);
    check("rst_done",  done_a,  0);
    check("rst_cnt",   cnt_a,   0);
    check("rst_valid", valid_a, 0);
    check("rst_data",  data_a,  0);
`ifdef PLA_SWEEP_MISR_EN
    check("rst_sig",   sig_a,   16'hFFFF);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", busy_a, 0);

    // Asynchronous reset in the middle of a sweep
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 0;
    while (x_a != 16'h1234 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_1234", x_a, 16'h1234);
    check("mid_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x",     x_a,     0);
    check("mid_rst_busy",  busy_a,  0);
    check("mid_rst_cnt",   cnt_a,   0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_data",  data_a,  0);
    check("mid_rst_done",  done_a,  0);
    @(negedge clk) rst_n = 1'b1;

    // Full-rate sweep of the test cone, with start pulses while busy
    got_a.delete();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 70000) begin
      start_a = (cyc == 100 || cyc == 60000);
      @(negedge clk);
      cyc++;
      if (cyc == 101) check("a_busy_mid", busy_a, 1);
    end
    start_a = 1'b0;
    check("a_done_latency", cyc, 32'd65538);
    check("a_done", done_a, 1);
    check("a_busy_at_done", busy_a, 0);
    check("a_onset_cnt", cnt_a, 17'd96);
    check("a_beats", got_a.size(), 96);
    check("a_first", (got_a.size() > 0) ? got_a[0] : 16'hDEAD, 16'h00E0);
    check_list("a_list", got_a, model_list(16, 0));
    check("a_has_01D0", q_has(got_a, 16'h01D0), 1);
    check("a_has_02D0", q_has(got_a, 16'h02D0), 1);
    check("a_no_03D0",  q_has(got_a, 16'h03D0), 0);
    check("a_no_00F0",  q_has(got_a, 16'h00F0), 0);
    check("a_x_parked", x_a, 16'hFFFF);
    @(negedge clk);
    check("a_done_pulse", done_a, 0);
    repeat (5) @(negedge clk);
    check("a_cnt_hold_idle", cnt_a, 17'd96);

    // Backpressure on the 12-bit instance, seeded pseudo-random ready
    seed_val = $urandom(1);
    mon_b = 1'b1;
    run_b(1'b1, cyc);
    mon_b = 1'b0;
    check("b_bp_cnt", cnt_b, 13'd6);
    check_list("b_bp_list", got_b, model_list(12, 0));
`ifdef PLA_SWEEP_MISR_EN
    sig1 = sig_b;
`endif

    // Constant cone at full rate
    mode_b = 1;
    run_b(1'b0, cyc);
    check("b_const_latency", cyc, 32'd4098);
    check("b_const_cnt", cnt_b, 13'h1000);
    check("b_const_last", (got_b.size() > 0) ? got_b[$] : 16'hDEAD, 16'h0FFF);
    check_list("b_const_list", got_b, model_list(12, 1));

    // start sampled in DONE restarts immediately
    mode_b = 0;
    got_b.delete();
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_restart_busy", busy_b, 1);
    wait_done_b(1'b0, cyc);
    check("b_restart_latency", cyc, 32'd4098);
    check("b_restart_cnt", cnt_b, 13'd6);
    check_list("b_restart_list", got_b, model_list(12, 0));

`ifdef PLA_SWEEP_MISR_EN
    sig2 = sig_b;
    check("sig_repeatable", sig2, sig1);
    mode_b = 2;
    run_b(1'b0, cyc);
    check("b_flip_cnt", cnt_b, 13'd5);
    check("sig_sensitive", sig_b != sig1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
